// File: rtl/mem_pkg.sv
// Shared sizing and word type for the 512 x 32 memory, reused by the CPU and the loader.
package mem_pkg;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 512;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage : mem_pkg

// File: rtl/mem512_32.sv
// Single-port 512-word x 32-bit memory: synchronous write, combinational read,
// asynchronous active-low clear of the whole array.
module mem512_32
   import mem_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  wEn,
   input  addr_t addr,
   input  word_t din,
   output word_t dout
);

   // Storage is a flop array rather than an SRAM macro, because every word must
   // clear the moment rst falls.
   word_t mem [DEPTH];

   // Clear everything on rst low; otherwise write one word per rising edge when enabled.
   // A write edge that arrives while rst is low is swallowed by the reset branch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wEn) begin
         mem[addr] <= din;
      end
   end

   // Zero-latency read. A write becomes visible right after its edge, and an
   // address change becomes visible without waiting for any edge.
   assign dout = mem[addr];

endmodule : mem512_32

// File: tb/tb_mem512_32.sv
// Self-checking bench for mem512_32: directed steps, then random traffic checked
// against a plain array model of the memory.
module tb_mem512_32;
   import mem_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  wEn;
   addr_t addr;
   word_t din;
   word_t dout;

   int checks   = 0;
   int failures = 0;

   // Reference contents: what each address should hold right now.
   word_t model [DEPTH];

   mem512_32 dut (
      .clk  (clk),
      .rst  (rst),
      .wEn  (wEn),
      .addr (addr),
      .din  (din),
      .dout (dout)
   );

   // 10 ns period: rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic check(input string tag, input word_t got, input word_t exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: dout=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   // Drive inputs on the falling edge, let one rising edge pass, update the model,
   // then step 1 ns past the edge so outputs are sampled away from it.
   task automatic cycle(input addr_t a, input word_t d, input logic we);
      @(negedge clk);
      addr = a;
      din  = d;
      wEn  = we;
      @(posedge clk);
      if (we && rst) model[a] = d;
      #1;
   endtask

   // Loader program fragment streamed into consecutive addresses.
   word_t prog [8];
   addr_t a;
   addr_t ra;
   word_t d;
   logic  we;

   initial begin
      prog[0] = 32'h20080005; prog[1] = 32'h2009000C;
      prog[2] = 32'h01095020; prog[3] = 32'hAD0A0000;
      prog[4] = 32'h8D0B0000; prog[5] = 32'h1109FFFE;
      prog[6] = 32'h08000000; prog[7] = 32'hFFFFFFFF;

      rst  = 1'b0;
      wEn  = 1'b0;
      addr = '0;
      din  = '0;
      model_clear();

      // Reset state: everything reads zero.
      #2;
      check("rst_state_0", dout, 32'h0);
      addr = 9'd511;
      #1;
      check("rst_state_511", dout, 32'h0);
      #9;                       // t=12, between edges
      rst = 1'b1;

      // Test 1: asynchronous clear mid-cycle, visible before the next edge.
      cycle(9'd5, 32'hDEADBEEF, 1'b1);
      check("wr_addr5", dout, 32'hDEADBEEF);
      #1;
      rst = 1'b0;
      model_clear();
      #1;
      check("async_clear_addr5", dout, 32'h0);
      addr = 9'd0;
      #1;
      check("async_clear_addr0", dout, 32'h0);
      addr = 9'd511;
      #1;
      check("async_clear_addr511", dout, 32'h0);
      // Write edge while rst is still low must be ignored.
      cycle(9'd7, 32'hCAFEF00D, 1'b1);
      check("write_blocked_in_reset", dout, 32'h0);
      #1;
      rst = 1'b1;

      // Test 2: streamed loader writes, each visible 1 ns after its edge.
      for (int i = 0; i < 8; i++) begin
         cycle(9'(200 + i), prog[i], 1'b1);
         check($sformatf("stream_wr_%0d", 200 + i), dout, prog[i]);
      end
      @(negedge clk);
      wEn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         addr = 9'(200 + i);
         #1;
         check($sformatf("stream_rd_%0d", 200 + i), dout, prog[i]);
      end

      // Test 3: write inhibit over three edges.
      repeat (3) cycle(9'd10, 32'h12345678, 1'b0);
      check("inhibit_addr10", dout, 32'h0);

      // Test 4: overwrite on consecutive edges.
      cycle(9'd300, 32'hAAAA5555, 1'b1);
      cycle(9'd300, 32'h5555AAAA, 1'b1);
      check("overwrite_300", dout, 32'h5555AAAA);

      // Test 5: boundary addresses and 9-bit driver wrap.
      cycle(9'd0, 32'h00000001, 1'b1);
      check("bound_wr_0", dout, 32'h00000001);
      cycle(9'd511, 32'hFFFFFFFF, 1'b1);
      check("bound_wr_511", dout, 32'hFFFFFFFF);
      @(negedge clk);
      wEn  = 1'b0;
      addr = 9'd1;
      #1;
      check("bound_neighbour_1", dout, 32'h0);
      addr = 9'd510;
      #1;
      check("bound_neighbour_510", dout, 32'h0);
      a = 9'd511;
      a = a + 9'd1;
      addr = a;
      #1;
      check("bound_wrap_to_0", dout, 32'h00000001);

      // Test 6: combinational read, address flips with no edge in between.
      @(negedge clk);
      wEn  = 1'b0;
      addr = 9'd200;
      #1;
      check("comb_rd_200", dout, prog[0]);
      addr = 9'd201;
      #1;
      check("comb_rd_201", dout, prog[1]);
      addr = 9'd200;
      #1;
      check("comb_rd_200_again", dout, prog[0]);

      // Random traffic: mostly a small address window so reads hit earlier writes,
      // plus a mid-cycle random read and the occasional asynchronous clear.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) a = 9'($urandom_range(0, DEPTH - 1));
         else                           a = 9'($urandom_range(0, 31));
         d  = $urandom;
         we = 1'($urandom_range(0, 1));
         cycle(a, d, we);
         check("rand_post_edge", dout, model[a]);
         #1;
         ra   = 9'($urandom_range(0, 31));
         addr = ra;
         #1;
         check("rand_mid_cycle", dout, model[ra]);
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b0;
            model_clear();
            #1;
            check("rand_async_clear", dout, 32'h0);
            rst = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mem512_32
